core_clock_scheduler: RTL and testbench

- Sequences the per-core trigger inputs of the clock_corrector instances in the multicore matrix-multiply array.
- On one start request, releases the cores one at a time with a fixed stagger. This limits simultaneous clock start-up.
- Collects per-core done flags and reports completion.
- A watchdog aborts the run if the cores stall.

---
 rtl/core_sched_pkg.sv | 22 ++
 rtl/sched_down_counter.sv | 39 +++
 rtl/core_clock_scheduler.sv | 153 +++++++++++++++
 tb/tb_core_clock_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/core_sched_pkg.sv
// Shared definitions for the per-core clock trigger scheduler: FSM state
// encoding and the default array dimensions used by the matmul top level.
package core_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RELEASE = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_ERROR   = 3'd4
    } sched_state_e;

    localparam int NUM_CORES_DEF = 4;
    localparam int STAGGER_DEF   = 3;
    localparam int TIMEOUT_DEF   = 64;

    // Triggers are held and busy is asserted only while the run is live.
    function automatic logic is_active(input sched_state_e s);
        return (s == S_RELEASE) || (s == S_RUN);
    endfunction

endpackage

// File: rtl/sched_down_counter.sv
// Loadable down counter that saturates at zero; tc flags the zero count.
module sched_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority over decrement; the count never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == {W{1'b0}});

endmodule

// File: rtl/core_clock_scheduler.sv
// Releases the per-core clock_corrector triggers one at a time with a fixed
// stagger, gathers per-core done flags and aborts the run on a watchdog expiry.
module core_clock_scheduler
    import core_sched_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int STAGGER   = STAGGER_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] core_done,
    output logic [NUM_CORES-1:0] core_trigger,
    output logic                 busy,
    output logic                 all_done,
    output logic                 timeout_err
);

    localparam int IDX_W = $clog2(NUM_CORES + 1);
    localparam int STG_W = $clog2(STAGGER + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    sched_state_e         state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_CORES-1:0] trig_q, trig_d;
    logic [NUM_CORES-1:0] done_seen_q, done_seen_d;
    logic                 busy_q, busy_d;
    logic                 all_done_q, all_done_d;
    logic                 timeout_err_q, timeout_err_d;

    logic stg_load_s, stg_dec_s, stg_tc_s;
    logic wd_load_s, wd_dec_s, wd_tc_s;

    sched_down_counter #(.W(STG_W)) u_stagger (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (stg_load_s),
        .dec      (stg_dec_s),
        .load_val (STG_W'(STAGGER - 1)),
        .tc       (stg_tc_s)
    );

    sched_down_counter #(.W(WD_W)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wd_load_s),
        .dec      (wd_dec_s),
        .load_val (WD_W'(TIMEOUT - 1)),
        .tc       (wd_tc_s)
    );

    // Next-state, trigger release and done collection; idx counts triggers already set.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        trig_d      = trig_q;
        done_seen_d = done_seen_q;
        stg_load_s  = 1'b0;
        stg_dec_s   = 1'b0;
        wd_load_s   = 1'b0;
        wd_dec_s    = 1'b0;

        if (is_active(state_q)) begin
            done_seen_d = done_seen_q | (core_done & trig_q);
        end else begin
            done_seen_d = done_seen_q;
        end

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_d     = S_RELEASE;
                    trig_d      = NUM_CORES'(1);
                    idx_d       = IDX_W'(1);
                    stg_load_s  = 1'b1;
                    done_seen_d = {NUM_CORES{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_RELEASE: begin
                if (idx_q == IDX_W'(NUM_CORES)) begin
                    state_d   = S_RUN;
                    wd_load_s = 1'b1;
                end else if (stg_tc_s) begin
                    trig_d     = trig_q | (NUM_CORES'(1) << idx_q);
                    idx_d      = idx_q + IDX_W'(1);
                    stg_load_s = 1'b1;
                end else begin
                    stg_dec_s = 1'b1;
                end
            end
            S_RUN: begin
                if (&done_seen_q) begin
                    state_d = S_DONE;
                end else if (wd_tc_s) begin
                    state_d = S_ERROR;
                end else begin
                    wd_dec_s = 1'b1;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                idx_d       = {IDX_W{1'b0}};
                done_seen_d = {NUM_CORES{1'b0}};
            end
            default: begin
                state_d     = S_IDLE;
                idx_d       = {IDX_W{1'b0}};
                trig_d      = {NUM_CORES{1'b0}};
                done_seen_d = {NUM_CORES{1'b0}};
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        if (is_active(state_d)) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
            trig_d = {NUM_CORES{1'b0}};
        end
        all_done_d    = (state_d == S_DONE);
        timeout_err_d = (state_d == S_ERROR);
    end

    // State and output registers; reset drops every trigger on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= {IDX_W{1'b0}};
            trig_q        <= {NUM_CORES{1'b0}};
            done_seen_q   <= {NUM_CORES{1'b0}};
            busy_q        <= 1'b0;
            all_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            trig_q        <= trig_d;
            done_seen_q   <= done_seen_d;
            busy_q        <= busy_d;
            all_done_q    <= all_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign core_trigger = trig_q;
    assign busy         = busy_q;
    assign all_done     = all_done_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_core_clock_scheduler.sv
// Self-checking bench for core_clock_scheduler: vector table, corner sequences
// and a randomized run against a time-based reference model.
module tb_core_clock_scheduler;

    localparam int N = 4;
    localparam int S = 3;
    localparam int T = 64;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] core_done;
    logic [N-1:0] core_trigger;
    logic         busy;
    logic         all_done;
    logic         timeout_err;

    int tests_run;
    int tests_failed;

    core_clock_scheduler #(.NUM_CORES(N), .STAGGER(S), .TIMEOUT(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .core_done    (core_done),
        .core_trigger (core_trigger),
        .busy         (busy),
        .all_done     (all_done),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 active (release+run), 2 done, 3 error.
    // Trigger k is high from cycle t0 + k*S while active.
    int           m_mode;
    int           m_t0;
    int           m_cyc;
    logic [N-1:0] m_seen;
    logic [N-1:0] e_trig;
    logic         e_busy, e_ad, e_te;

    task automatic model_update();
        logic [N-1:0] vis;
        int run_start;
        for (int k = 0; k < N; k++)
            vis[k] = (m_mode == 1) && (m_cyc >= m_t0 + k * S);
        run_start = m_t0 + (N - 1) * S + 1;
        if (!rst_n) begin
            m_mode = 0;
            m_seen = '0;
        end else begin
            case (m_mode)
                0, 3: if (start) begin
                    m_mode = 1;
                    m_t0   = m_cyc + 1;
                    m_seen = '0;
                end
                1: begin
                    if (m_cyc >= run_start && (&m_seen))
                        m_mode = 2;
                    else if (m_cyc >= run_start && (m_cyc - run_start) == T - 1)
                        m_mode = 3;
                    m_seen = m_seen | (core_done & vis);
                end
                default: begin
                    m_mode = 0;
                    m_seen = '0;
                end
            endcase
        end
        m_cyc++;
        for (int k = 0; k < N; k++)
            e_trig[k] = (m_mode == 1) && (m_cyc >= m_t0 + k * S);
        e_busy = (m_mode == 1);
        e_ad   = (m_mode == 2);
        e_te   = (m_mode == 3);
    endtask

    task automatic check(input string name, input logic [N-1:0] et, input logic eb,
                         input logic ea, input logic ee);
        tests_run++;
        if (core_trigger !== et || busy !== eb || all_done !== ea || timeout_err !== ee) begin
            tests_failed++;
            $display("FAIL %s cyc=%0d got trig=%b busy=%b all_done=%b terr=%b want trig=%b busy=%b all_done=%b terr=%b",
                     name, m_cyc, core_trigger, busy, all_done, timeout_err, et, eb, ea, ee);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [N-1:0] d);
        rst_n     = r;
        start     = s;
        core_done = d;
        @(posedge clk);
        model_update();
        #1;
        check("model", e_trig, e_busy, e_ad, e_te);
    endtask

    typedef struct {
        int           rep;
        logic         r;
        logic         s;
        logic [N-1:0] d;
        logic [N-1:0] trig;
        logic         busy;
        logic         ad;
        logic         te;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [N-1:0] d;
        tests_run    = 0;
        tests_failed = 0;
        m_mode = 0; m_t0 = 0; m_cyc = 0; m_seen = '0;
        rst_n = 1'b0; start = 1'b0; core_done = '0;

        // Reset, idle, then one full run: each row's inputs are held for rep
        // cycles and the outputs after every one of those edges must match.
        vecs[0] = '{2,  1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{10, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1,  1'b1, 1'b1, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{2,  1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{3,  1'b1, 1'b0, 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{3,  1'b1, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{6,  1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1,  1'b1, 1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1,  1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{3,  1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < vecs[v].rep; i++) begin
                step(vecs[v].r, vecs[v].s, vecs[v].d);
                check($sformatf("vec%0d", v), vecs[v].trig, vecs[v].busy, vecs[v].ad, vecs[v].te);
            end
        end

        // Early done from an untriggered core is ignored; the run times out.
        step(1'b1, 1'b1, 4'b0000);
        for (int i = 0; i < 73; i++)
            step(1'b1, 1'b0, (i == 2) ? 4'b1000 : 4'b0000);
        check("t3_pre_timeout", 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'b0000);
        check("t3_timeout", 4'b0000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b1111);
        check("t3_sticky", 4'b0000, 1'b0, 1'b0, 1'b1);

        // Restart from ERROR and complete normally.
        step(1'b1, 1'b1, 4'b0000);
        check("t4_restart", 4'b0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 4'b0000);
        check("t4_all_trig", 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'b1111);
        step(1'b1, 1'b0, 4'b0000);
        check("t4_all_done", 4'b0000, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'b0000);
        check("t4_idle", 4'b0000, 1'b0, 1'b0, 1'b0);

        // start held high throughout: no retrigger, DONE ignores it, IDLE accepts it.
        step(1'b1, 1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'b0000);
        check("t5_no_retrig", 4'b0011, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'b0000);
        step(1'b1, 1'b1, 4'b1111);
        step(1'b1, 1'b1, 4'b0000);
        check("t5_all_done", 4'b0000, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 4'b0000);
        check("t5_done_ignores", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'b0000);
        check("t5_rerelease", 4'b0001, 1'b1, 1'b0, 1'b0);

        // Mid-run reset drops triggers and forgets core 0's done.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b0001);
        check("t6_two_trig", 4'b0011, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0000);
        check("t6_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b0000);
        check("t6_core0_first", 4'b0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b1110);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b0000);
        check("t6_seen_lost", 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'b0001);
        step(1'b1, 1'b0, 4'b0000);
        check("t6_all_done", 4'b0000, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'b0000);
        check("t6_idle", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < N; k++)
                d[k] = ($urandom_range(0, 39) == 0);
            step(($urandom_range(0, 249) != 0), ($urandom_range(0, 7) == 0), d);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
